// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store initiator.
// Turns a pipeline memory op into a single req/ack transaction on the data-memory port.
// It generates the word address, the byte enables and lane-replicated store data.
// It extracts and extends load data from the returned word.
// It stalls the pipeline until one of three things happens: the memory acks, the access
// times out, or the access is rejected as misaligned.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles in REQ without mem_ack before the access aborts with err (>=1)
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   op_valid          M-stage holds a memory op this cycle
//   op_store          1=store, 0=load
//   op_size           0=byte, 1=half, 2/3=word
//   op_signed         sign-extend byte/half loads
//   addr, wdata, pc   byte address, right-aligned store data, PC (trace only)
//   stall             freeze upstream pipeline
//   done, err         op finished pulse; err flags misalign or timeout
//   rdata             extended load result, held until the next load completes
//   mem_req, mem_we   registered request / write strobe to data memory
//   mem_be            byte enables, bit i = byte lane i
//   mem_addr          word-aligned address
//   mem_wdata         lane-replicated store data
//   mem_rdata         read word, valid with mem_ack (old word on write-ack)
//   mem_ack           single-cycle completion from memory
//
// Configuration
//   MEM_TRACE_EN      when defined, prints each acknowledged store with the merged memory word

module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic        op_store,
   input  logic [1:0]  op_size,
   input  logic        op_signed,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [31:0] pc,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             err_q;
   logic             lat_store;
   logic [1:0]       lat_size;
   logic             lat_signed;
   logic [1:0]       lat_lo;
   logic [31:0]      pc_q;

   logic             is_byte;
   logic             is_half;
   logic             misaligned;
   logic [3:0]       be_next;
   logic [31:0]      wdata_next;
   logic [7:0]       byte_lane;
   logic [15:0]      half_lane;
   logic [31:0]      load_ext;

   // Decode of the incoming op: alignment, byte enables, replicated store data
   always_comb begin
      is_byte    = (op_size == 2'd0);
      is_half    = (op_size == 2'd1);
      misaligned = (is_half & addr[0]) |
                   (~is_byte & ~is_half & (addr[1:0] != 2'b00));
      be_next    = 4'b1111;
      wdata_next = wdata;
      if (is_byte) begin
         be_next    = 4'b0001 << addr[1:0];
         wdata_next = {4{wdata[7:0]}};
      end else if (is_half) begin
         be_next    = addr[1] ? 4'b1100 : 4'b0011;
         wdata_next = {2{wdata[15:0]}};
      end
   end

   // Lane extraction from the returned word, using the latched op copy
   always_comb begin
      byte_lane = mem_rdata[7:0];
      case (lat_lo)
         2'd0:    byte_lane = mem_rdata[7:0];
         2'd1:    byte_lane = mem_rdata[15:8];
         2'd2:    byte_lane = mem_rdata[23:16];
         default: byte_lane = mem_rdata[31:24];
      endcase
      half_lane = lat_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_ext  = mem_rdata;
      case (lat_size)
         2'd0:    load_ext = {{24{lat_signed & byte_lane[7]}}, byte_lane};
         2'd1:    load_ext = {{16{lat_signed & half_lane[15]}}, half_lane};
         default: load_ext = mem_rdata;
      endcase
   end

   // Handshake outputs: IDLE reacts to the op in the same cycle, DONE reports the latched result
   always_comb begin
      stall = 1'b0;
      done  = 1'b0;
      err   = 1'b0;
      if (!reset) begin
         case (state)
            S_IDLE: begin
               if (op_valid) begin
                  if (misaligned) begin
                     done = 1'b1;
                     err  = 1'b1;
                  end else begin
                     stall = 1'b1;
                  end
               end
            end
            S_REQ:   stall = 1'b1;
            S_DONE: begin
               done = 1'b1;
               err  = err_q;
            end
            default: ;
         endcase
      end
   end

   // Transaction FSM with registered memory-port outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         err_q      <= 1'b0;
         lat_store  <= 1'b0;
         lat_size   <= 2'd0;
         lat_signed <= 1'b0;
         lat_lo     <= 2'd0;
         pc_q       <= '0;
         rdata      <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (op_valid && !misaligned) begin
                  state      <= S_REQ;
                  // Counter holds the number of REQ cycles including the current one
                  cnt        <= CNT_ONE;
                  err_q      <= 1'b0;
                  lat_store  <= op_store;
                  lat_size   <= op_size;
                  lat_signed <= op_signed;
                  lat_lo     <= addr[1:0];
                  pc_q       <= pc;
                  mem_req    <= 1'b1;
                  mem_we     <= op_store;
                  mem_be     <= be_next;
                  mem_addr   <= {addr[31:2], 2'b00};
                  mem_wdata  <= wdata_next;
               end
            end
            S_REQ: begin
               // An ack on the final allowed cycle still completes cleanly
               if (mem_ack) begin
                  state   <= S_DONE;
                  err_q   <= 1'b0;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (!lat_store) begin
                     rdata <= load_ext;
                  end
               end else if (cnt == CNT_MAX) begin
                  state   <= S_DONE;
                  err_q   <= 1'b1;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (!lat_store) begin
                     rdata <= '0;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               cnt   <= '0;
               err_q <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef MEM_TRACE_EN
   logic [31:0] merged_word;

   // Memory returns the old word on write-ack; overlay the written lanes
   always_comb begin
      merged_word = mem_rdata;
      for (int i = 0; i < 4; i++) begin
         if (mem_be[i]) begin
            merged_word[8*i +: 8] = mem_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && (state == S_REQ) && mem_ack && lat_store) begin
         $display("%d@%h: *%h <= %h", $time, pc_q, mem_addr, merged_word);
      end
   end
`else
   logic unused_trace;
   assign unused_trace = ^pc_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit.
// Each op pushes its expected result; a negedge monitor checks the memory port
// during REQ and pops/compares the result when done pulses.

module tb_mem_access_unit;

   localparam int unsigned TB_TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic        op_store;
   logic [1:0]  op_size;
   logic        op_signed;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] pc;
   logic        stall;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        ack_m = 1'b0;
   logic        ack_f;
   logic        mem_ack;

   assign mem_ack = ack_m | ack_f;

   mem_access_unit #(
      .TIMEOUT_CYCLES(TB_TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .op_valid  (op_valid),
      .op_store  (op_store),
      .op_size   (op_size),
      .op_signed (op_signed),
      .addr      (addr),
      .wdata     (wdata),
      .pc        (pc),
      .stall     (stall),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          stall_cyc;
      int          req_cyc;
      logic        we;
      logic [3:0]  be;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      bit          chk_wdata;
   } exp_t;

   exp_t        sb_q[$];
   int          n_chk     = 0;
   int          n_fail    = 0;
   int          ack_dly   = -1;
   int          stall_cnt = 0;
   int          req_cnt   = 0;
   logic [31:0] hold      = 32'h0;
   string       cur_tag   = "";

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] lo);
      case (sz)
         2'd0: begin
            case (lo)
               2'd0:    return 4'b0001;
               2'd1:    return 4'b0010;
               2'd2:    return 4'b0100;
               default: return 4'b1000;
            endcase
         end
         2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
      case (sz)
         2'd0:    return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
         2'd1:    return {wd[15:0], wd[15:0]};
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg,
                                          input logic [1:0] lo, input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      case (lo)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = lo[1] ? rd[31:16] : rd[15:0];
      case (sz)
         2'd0:    return (sg && b[7]) ? {24'hFFFFFF, b} : {24'h000000, b};
         2'd1:    return (sg && h[15]) ? {16'hFFFF, h} : {16'h0000, h};
         default: return rd;
      endcase
   endfunction

   // Drive one op, push its expectation, hold op_valid until done (bounded)
   task automatic do_op(input string tag, input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int dly, input bit scr);
      exp_t e;
      bit   mis;
      bit   got;
      int   rq;
      mis = ((sz == 2'd1) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
      if (mis) begin
         e.err = 1'b1;
         rq    = 0;
      end else if (dly >= 0 && dly < int'(TB_TIMEOUT)) begin
         e.err = 1'b0;
         rq    = dly + 1;
         if (!st) hold = m_load(sz, sg, a[1:0], mem_rdata);
      end else begin
         e.err = 1'b1;
         rq    = int'(TB_TIMEOUT);
         if (!st) hold = 32'h0;
      end
      e.req_cyc   = rq;
      e.stall_cyc = mis ? 0 : rq + 1;
      e.rdata     = hold;
      e.we        = st;
      e.be        = m_be(sz, a[1:0]);
      e.maddr     = {a[31:2], 2'b00};
      e.mwdata    = m_wdata(sz, wd);
      e.chk_wdata = st;
      sb_q.push_back(e);
      cur_tag   = tag;
      ack_dly   = dly;
      op_valid  = 1'b1;
      op_store  = st;
      op_size   = sz;
      op_signed = sg;
      addr      = a;
      wdata     = wd;
      pc        = $urandom;
      got       = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
         if (scr && n == 0) begin
            @(posedge clk);
            #1;
            addr      = ~a;
            wdata     = ~wd;
            op_size   = ~sz;
            op_store  = ~st;
            op_signed = ~sg;
         end
      end
      if (!got) begin
         check({tag, ":done_seen"}, 32'd0, 32'd1);
         sb_q.delete();
      end
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      ack_dly  = -1;
   endtask

   // Memory responder and scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         stall_cnt = 0;
         req_cnt   = 0;
         ack_m     = 1'b0;
      end else begin
         if (stall) stall_cnt++;
         if (mem_req) begin
            req_cnt++;
            if (sb_q.size() > 0) begin
               check({cur_tag, ":mem_we"}, 32'(mem_we), 32'(sb_q[0].we));
               check({cur_tag, ":mem_be"}, 32'(mem_be), 32'(sb_q[0].be));
               check({cur_tag, ":mem_addr"}, mem_addr, sb_q[0].maddr);
               if (sb_q[0].chk_wdata) check({cur_tag, ":mem_wdata"}, mem_wdata, sb_q[0].mwdata);
            end
            ack_m = (ack_dly >= 0) && (req_cnt == ack_dly + 1);
         end else begin
            ack_m = 1'b0;
         end
         if (done) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 32'(done), 32'd0);
            end else begin
               e = sb_q.pop_front();
               check({cur_tag, ":err"}, 32'(err), 32'(e.err));
               check({cur_tag, ":rdata"}, rdata, e.rdata);
               check({cur_tag, ":stall_cycles"}, 32'(stall_cnt), 32'(e.stall_cyc));
               check({cur_tag, ":req_cycles"}, 32'(req_cnt), 32'(e.req_cyc));
               stall_cnt = 0;
               req_cnt   = 0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int seen;
      reset     = 1'b1;
      op_valid  = 1'b0;
      op_store  = 1'b0;
      op_size   = 2'd0;
      op_signed = 1'b0;
      addr      = 32'h0;
      wdata     = 32'h0;
      pc        = 32'h0;
      ack_f     = 1'b0;
      mem_rdata = 32'h0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst:stall", 32'(stall), 32'd0);
      check("rst:done", 32'(done), 32'd0);
      check("rst:err", 32'(err), 32'd0);
      check("rst:rdata", rdata, 32'h0);
      check("rst:mem_req", 32'(mem_req), 32'd0);
      check("rst:mem_we", 32'(mem_we), 32'd0);
      check("rst:mem_be", 32'(mem_be), 32'd0);
      check("rst:mem_addr", mem_addr, 32'h0);
      check("rst:mem_wdata", mem_wdata, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Stores
      mem_rdata = 32'h0;
      do_op("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1, 1'b0);
      do_op("sb_13", 1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, 0, 1'b0);
      do_op("sh_12", 1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 0, 1'b0);
      do_op("sb_11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h123456C7, 2, 1'b0);
      do_op("sh_10", 1'b1, 2'd1, 1'b0, 32'h10, 32'hABCD5678, 0, 1'b0);

      // Loads with extension
      mem_rdata = 32'h80FF0011;
      do_op("lb_13",  1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, 1'b0);
      do_op("lbu_13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1, 1'b0);
      do_op("lh_12",  1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, 1'b1);
      do_op("lhu_10", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 2, 1'b0);
      do_op("lb_11",  1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0, 1'b0);
      do_op("lbu_12", 1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 0, 1'b0);
      do_op("lw_14",  1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0, 1'b0);
      mem_rdata = 32'hC0DE7F3A;
      do_op("lsz3_18", 1'b0, 2'd3, 1'b1, 32'h18, 32'h0, 1, 1'b0);

      // Misaligned rejects; rdata must hold
      do_op("lw_06_mis", 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 0, 1'b0);
      do_op("sh_11_mis", 1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, 0, 1'b0);
      do_op("sw_1f_mis", 1'b1, 2'd3, 1'b0, 32'h1F, 32'h1234, 0, 1'b0);

      // Spurious ack while idle is ignored
      @(posedge clk);
      #1;
      ack_f = 1'b1;
      @(negedge clk);
      check("spur_ack:done", 32'(done), 32'd0);
      check("spur_ack:mem_req", 32'(mem_req), 32'd0);
      @(posedge clk);
      #1;
      ack_f = 1'b0;
      @(negedge clk);
      check("spur_ack:done2", 32'(done), 32'd0);
      check("spur_ack:stall", 32'(stall), 32'd0);
      check("spur_ack:rdata", rdata, hold);
      @(posedge clk);
      #1;

      // Timeouts and ack on the last allowed cycle
      mem_rdata = 32'h00007F80;
      do_op("lh_last_ack", 1'b0, 2'd1, 1'b1, 32'h20, 32'h0, int'(TB_TIMEOUT) - 1, 1'b0);
      do_op("lw_timeout", 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, -1, 1'b0);
      mem_rdata = 32'h11223344;
      do_op("lw_28", 1'b0, 2'd2, 1'b0, 32'h28, 32'h0, 0, 1'b0);
      do_op("sw_timeout", 1'b1, 2'd2, 1'b0, 32'h2C, 32'hCAFEF00D, -1, 1'b0);

      // Reset during REQ cycle 2
      ack_dly   = -1;
      op_valid  = 1'b1;
      op_store  = 1'b0;
      op_size   = 2'd2;
      op_signed = 1'b0;
      addr      = 32'h30;
      seen      = 0;
      for (int n = 0; n < 20 && seen < 2; n++) begin
         @(negedge clk);
         if (mem_req) seen++;
      end
      check("rst_req:req_cycles_before", 32'(seen), 32'd2);
      #1;
      reset    = 1'b1;
      op_valid = 1'b0;
      @(negedge clk);
      check("rst_req:mem_req", 32'(mem_req), 32'd0);
      check("rst_req:done", 32'(done), 32'd0);
      check("rst_req:rdata", rdata, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      hold  = 32'h0;
      @(negedge clk);
      check("rst_req:done_after", 32'(done), 32'd0);
      check("rst_req:mem_req_after", 32'(mem_req), 32'd0);
      @(posedge clk);
      #1;

      // Normal op after reset recovery
      mem_rdata = 32'hFFFF8001;
      do_op("lh_after_rst", 1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 1, 1'b0);
      do_op("lhu_after_rst", 1'b0, 2'd1, 1'b0, 32'h30, 32'h0, 0, 1'b0);

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
